raster_cmd_scheduler: RTL and testbench

RASTER_CMD_SCHEDULER -- requirements
Module: raster_cmd_scheduler

---
 rtl/raster_cmd_scheduler_pkg.sv | 57 +++++
 rtl/raster_cmd_scheduler_if.sv | 25 ++
 rtl/raster_cmd_scheduler_arb.sv | 25 ++
 rtl/raster_cmd_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_raster_cmd_scheduler.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/raster_cmd_scheduler_pkg.sv
// Shared raster definitions: scheduler state and op encodings, command word
// layout and screen coordinate widths.
package raster_cmd_scheduler_pkg;

  localparam int unsigned SCR_XW = 10;
  localparam int unsigned SCR_YW = 9;
  localparam int unsigned CMD_W  = 58;

  localparam int unsigned OP_BIT = 57;
  localparam int unsigned X1_LSB = 47;
  localparam int unsigned Y1_LSB = 38;
  localparam int unsigned X2_LSB = 28;
  localparam int unsigned Y2_LSB = 19;
  localparam int unsigned X3_LSB = 9;
  localparam int unsigned Y3_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LN_START = 3'd1,
    S_LN_RUN   = 3'd2,
    S_TRI_RUN  = 3'd3,
    S_FINISH   = 3'd4
  } state_t;

  typedef enum logic {
    OP_LINE = 1'b0,
    OP_TRI  = 1'b1
  } op_t;

  typedef struct packed {
    op_t               op;
    logic [SCR_XW-1:0] x1;
    logic [SCR_YW-1:0] y1;
    logic [SCR_XW-1:0] x2;
    logic [SCR_YW-1:0] y2;
    logic [SCR_XW-1:0] x3;
    logic [SCR_YW-1:0] y3;
  } cmd_t;

  function automatic cmd_t unpack_cmd(input logic [CMD_W-1:0] raw);
    cmd_t c;
    c.op = op_t'(raw[OP_BIT]);
    c.x1 = raw[X1_LSB +: SCR_XW];
    c.y1 = raw[Y1_LSB +: SCR_YW];
    c.x2 = raw[X2_LSB +: SCR_XW];
    c.y2 = raw[Y2_LSB +: SCR_YW];
    c.x3 = raw[X3_LSB +: SCR_XW];
    c.y3 = raw[Y3_LSB +: SCR_YW];
    return c;
  endfunction

  // A triangle whose three vertices share one scanline has no area to fill.
  function automatic logic is_flat_tri(input cmd_t c);
    return (c.op == OP_TRI) && (c.y1 == c.y2) && (c.y2 == c.y3);
  endfunction

endpackage

// File: rtl/raster_cmd_scheduler_if.sv
// Requester-side bus of the raster command scheduler: requests, commands,
// grant and completion status.
interface raster_cmd_scheduler_if;
  import raster_cmd_scheduler_pkg::*;

  logic [1:0]       req;
  logic [CMD_W-1:0] cmd0;
  logic [CMD_W-1:0] cmd1;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic             done_id;
  logic             err;

  modport master (
    output req, cmd0, cmd1,
    input  gnt, busy, done, done_id, err
  );

  modport slave (
    input  req, cmd0, cmd1,
    output gnt, busy, done, done_id, err
  );

endinterface

// File: rtl/raster_cmd_scheduler_arb.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       pointer
);

  always_comb begin
    gnt = req;
    if (&req) gnt = pointer ? 2'b10 : 2'b01;
  end

  // After a grant the pointer moves to the requester that lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      pointer <= 1'b0;
    end else if (advance && |gnt) begin
      pointer <= gnt[0];
    end
  end

endmodule

// File: rtl/raster_cmd_scheduler.sv
// Raster command scheduler: arbitrates two requesters, drives the line or
// triangle engine for the granted command and forwards de-duplicated pixels.
module raster_cmd_scheduler
  import raster_cmd_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048575,
  parameter int unsigned NREQ           = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  raster_cmd_scheduler_if.slave host,
  output logic                  ln_start,
  output logic [31:0]           ln_x1,
  output logic [31:0]           ln_y1,
  output logic [31:0]           ln_x2,
  output logic [31:0]           ln_y2,
  input  logic                  ln_finish,
  input  logic [SCR_XW-1:0]     ln_x,
  input  logic [SCR_YW-1:0]     ln_y,
  output logic                  tri_reset,
  output logic [31:0]           tri_x1,
  output logic [31:0]           tri_y1,
  output logic [31:0]           tri_x2,
  output logic [31:0]           tri_y2,
  output logic [31:0]           tri_x3,
  output logic [31:0]           tri_y3,
  input  logic                  tri_finish,
  input  logic [SCR_XW-1:0]     tri_x,
  input  logic [SCR_YW-1:0]     tri_y,
  output logic                  pix_valid,
  output logic [SCR_XW-1:0]     pix_x,
  output logic [SCR_YW-1:0]     pix_y
);

  localparam logic [19:0] TIMEOUT_END = 20'(TIMEOUT_CYCLES);

  state_t            state;
  cmd_t              cmd_q;
  cmd_t              sel_cmd;
  logic              id_q;
  logic              err_q;
  logic [19:0]       run_cnt;
  logic [19:0]       run_cnt_inc;
  logic              first_q;
  logic [SCR_XW-1:0] prev_x;
  logic [SCR_YW-1:0] prev_y;
  logic [SCR_XW-1:0] cur_x;
  logic [SCR_YW-1:0] cur_y;
  logic              eng_finish;

  logic [NREQ-1:0]   arb_gnt;
  logic              arb_ptr;
  logic              arb_idx;

  logic [1:0]        gnt_q;
  logic              ln_start_q;
  logic              tri_reset_q;
  logic              pix_valid_q;
  logic [SCR_XW-1:0] pix_x_q;
  logic [SCR_YW-1:0] pix_y_q;
  logic              done_q;
  logic              done_id_q;
  logic              err_out_q;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (host.req),
    .advance (state == S_IDLE),
    .gnt     (arb_gnt),
    .pointer (arb_ptr)
  );

  assign arb_idx     = (&host.req) ? arb_ptr : host.req[1];
  assign sel_cmd     = unpack_cmd(arb_idx ? host.cmd1 : host.cmd0);
  assign run_cnt_inc = run_cnt + 20'd1;

  always_comb begin
    cur_x      = ln_x;
    cur_y      = ln_y;
    eng_finish = ln_finish;
    if (state == S_TRI_RUN) begin
      cur_x      = tri_x;
      cur_y      = tri_y;
      eng_finish = tri_finish;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cmd_q       <= '0;
      id_q        <= 1'b0;
      err_q       <= 1'b0;
      run_cnt     <= '0;
      first_q     <= 1'b0;
      prev_x      <= '0;
      prev_y      <= '0;
      gnt_q       <= '0;
      ln_start_q  <= 1'b0;
      tri_reset_q <= 1'b1;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
      err_out_q   <= 1'b0;
    end else begin
      gnt_q       <= '0;
      ln_start_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_out_q   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|host.req) begin
            gnt_q <= arb_gnt;
            id_q  <= arb_idx;
            cmd_q <= sel_cmd;
            err_q <= 1'b0;
            if (sel_cmd.op == OP_LINE) begin
              state      <= S_LN_START;
              ln_start_q <= 1'b1;
            end else if (is_flat_tri(sel_cmd)) begin
              state <= S_FINISH;
              err_q <= 1'b1;
            end else begin
              state       <= S_TRI_RUN;
              tri_reset_q <= 1'b0;
              run_cnt     <= '0;
              first_q     <= 1'b1;
            end
          end
        end
        S_LN_START: begin
          state   <= S_LN_RUN;
          run_cnt <= '0;
          first_q <= 1'b1;
        end
        S_LN_RUN, S_TRI_RUN: begin
          // Forward a pixel only when the engine moved, except the first run cycle.
          pix_valid_q <= first_q || ({cur_x, cur_y} != {prev_x, prev_y});
          pix_x_q     <= cur_x;
          pix_y_q     <= cur_y;
          prev_x      <= cur_x;
          prev_y      <= cur_y;
          first_q     <= 1'b0;
          run_cnt     <= run_cnt_inc;
          if (eng_finish) begin
            state       <= S_FINISH;
            tri_reset_q <= 1'b1;
          end else if (run_cnt_inc == TIMEOUT_END) begin
            state       <= S_FINISH;
            tri_reset_q <= 1'b1;
            err_q       <= 1'b1;
          end
        end
        S_FINISH: begin
          state     <= S_IDLE;
          done_q    <= 1'b1;
          done_id_q <= id_q;
          err_out_q <= err_q;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign host.gnt     = gnt_q;
  assign host.busy    = (state != S_IDLE);
  assign host.done    = done_q;
  assign host.done_id = done_id_q;
  assign host.err     = err_out_q;

  assign ln_start  = ln_start_q;
  assign tri_reset = tri_reset_q;
  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;

  assign ln_x1  = 32'(cmd_q.x1);
  assign ln_y1  = 32'(cmd_q.y1);
  assign ln_x2  = 32'(cmd_q.x2);
  assign ln_y2  = 32'(cmd_q.y2);
  assign tri_x1 = 32'(cmd_q.x1);
  assign tri_y1 = 32'(cmd_q.y1);
  assign tri_x2 = 32'(cmd_q.x2);
  assign tri_y2 = 32'(cmd_q.y2);
  assign tri_x3 = 32'(cmd_q.x3);
  assign tri_y3 = 32'(cmd_q.y3);

endmodule

// File: tb/tb_raster_cmd_scheduler.sv
// Directed bench for raster_cmd_scheduler: command table plus reset,
// idle-finish and round-robin sequences, with behavioural engine models.
module tb_raster_cmd_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        ln_start, ln_finish, tri_reset, tri_finish, pix_valid;
  logic [31:0] ln_x1, ln_y1, ln_x2, ln_y2;
  logic [31:0] tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3;
  logic [9:0]  ln_x, tri_x, pix_x;
  logic [8:0]  ln_y, tri_y, pix_y;

  raster_cmd_scheduler_if host ();

  raster_cmd_scheduler #(.TIMEOUT_CYCLES(16), .NREQ(2)) dut (
    .clk(clk), .reset(reset), .host(host),
    .ln_start(ln_start), .ln_x1(ln_x1), .ln_y1(ln_y1), .ln_x2(ln_x2), .ln_y2(ln_y2),
    .ln_finish(ln_finish), .ln_x(ln_x), .ln_y(ln_y),
    .tri_reset(tri_reset), .tri_x1(tri_x1), .tri_y1(tri_y1), .tri_x2(tri_x2),
    .tri_y2(tri_y2), .tri_x3(tri_x3), .tri_y3(tri_y3),
    .tri_finish(tri_finish), .tri_x(tri_x), .tri_y(tri_y),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int px_q[$];
  int py_q[$];
  int ln_start_cnt = 0;
  int tri_low_cnt  = 0;
  int done_cnt     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pix_valid) begin
      px_q.push_back(int'(pix_x));
      py_q.push_back(int'(pix_y));
    end
    if (ln_start)   ln_start_cnt++;
    if (!tri_reset) tri_low_cnt++;
    if (host.done)  done_cnt++;
  end

  typedef struct {
    logic [1:0] req;
    logic       op;
    int         x1, y1, x2, y2, x3, y3;
    bit         hang;
    logic [1:0] exp_gnt;
    int         exp_lat;     // cycles from gnt to done
    int         exp_npix;
    logic       exp_err;
    int         fx, fy, lx, ly;
    int         exp_tri_low;
    int         exp_ln_start;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [57:0] mk(input logic op, input int x1, input int y1,
                                     input int x2, input int y2, input int x3, input int y3);
    return {op, 10'(x1), 9'(y1), 10'(x2), 9'(y2), 10'(x3), 9'(y3)};
  endfunction

  task automatic chk_coords(input string name, input vec_t v);
    chk({name, "_tri_coords"},
        {tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3},
        {32'(v.x1), 32'(v.y1), 32'(v.x2), 32'(v.y2), 32'(v.x3), 32'(v.y3)});
    chk({name, "_ln_coords"}, {ln_x1, ln_y1, ln_x2, ln_y2},
        {32'(v.x1), 32'(v.y1), 32'(v.x2), 32'(v.y2)});
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int         p0, ls0, tl0, gcyc, dcyc;
    logic [1:0] g;
    bit         seen;
    logic       did, derr;
    string      tag;
    tag  = $sformatf("v%0d", idx);
    p0   = px_q.size();
    ls0  = ln_start_cnt;
    tl0  = tri_low_cnt;
    g    = '0;
    gcyc = 0;
    dcyc = 0;
    did  = 1'b0;
    derr = 1'b0;
    host.cmd0 = mk(v.op, v.x1, v.y1, v.x2, v.y2, v.x3, v.y3);
    host.cmd1 = host.cmd0;
    host.req  = v.req;
    for (int i = 0; i < 8 && g == 2'b00; i++) begin
      step();
      g = host.gnt;
    end
    chk({tag, "_gnt"}, g, v.exp_gnt);
    gcyc = cyc;
    host.req  = '0;
    host.cmd0 = '1;
    host.cmd1 = '1;
    chk_coords({tag, "_grant"}, v);

    if (v.op == 1'b0) begin
      tri_finish = 1'b1;
      step();
      if (v.hang) begin
        ln_x = 10'(v.x1);
        ln_y = 9'(v.y1);
      end else begin
        for (int x = v.x1; x <= v.x2; x++) begin
          ln_x      = 10'(x);
          ln_y      = 9'(v.y1);
          ln_finish = (x == v.x2);
          step();
        end
        ln_finish = 1'b0;
      end
    end else if (v.exp_tri_low != 0) begin
      for (int k = 0; k < 6; k++) begin
        case (k / 2)
          0:       begin tri_x = 10'(v.x1); tri_y = 9'(v.y1); end
          1:       begin tri_x = 10'(v.x2); tri_y = 9'(v.y2); end
          default: begin tri_x = 10'(v.x3); tri_y = 9'(v.y3); end
        endcase
        tri_finish = (k == 5);
        step();
      end
      tri_finish = 1'b0;
    end

    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (host.done) begin
        seen = 1'b1;
        dcyc = cyc;
        did  = host.done_id;
        derr = host.err;
      end else begin
        step();
      end
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      chk({tag, "_latency"}, dcyc - gcyc, v.exp_lat);
      chk({tag, "_done_id"}, did, v.exp_gnt[1]);
      chk({tag, "_err"}, derr, v.exp_err);
    end
    chk_coords({tag, "_hold"}, v);
    chk({tag, "_npix"}, px_q.size() - p0, v.exp_npix);
    if (v.exp_npix > 0 && px_q.size() > p0) begin
      chk({tag, "_first_pix"}, {px_q[p0], py_q[p0]}, {v.fx, v.fy});
      chk({tag, "_last_pix"}, {px_q[$], py_q[$]}, {v.lx, v.ly});
    end
    chk({tag, "_ln_start_cycles"}, ln_start_cnt - ls0, v.exp_ln_start);
    chk({tag, "_tri_reset_low_cycles"}, tri_low_cnt - tl0, v.exp_tri_low);
    tri_finish = 1'b0;
    ln_finish  = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] gseq[3];
    int         ng, d0;

    //                req    op    x1   y1   x2   y2  x3  y3  hang  gnt    lat npix err  fx   fy   lx   ly  tri ln
    tbl[0] = '{2'b01, 1'b0,    0,   0,   5,   0,  0,  0, 1'b0, 2'b01,  8,  6, 1'b0,   0,   0,   5,   0, 0, 1};
    tbl[1] = '{2'b10, 1'b0,    3, 100,   7, 100,  0,  0, 1'b0, 2'b10,  7,  5, 1'b0,   3, 100,   7, 100, 0, 1};
    tbl[2] = '{2'b01, 1'b1,   35,  40,  10,  20, 30, 60, 1'b0, 2'b01,  7,  3, 1'b0,  35,  40,  30,  60, 6, 0};
    tbl[3] = '{2'b10, 1'b1,    1,   7,   5,   7,  9,  7, 1'b0, 2'b10,  1,  0, 1'b1,   0,   0,   0,   0, 0, 0};
    tbl[4] = '{2'b01, 1'b0, 1023, 511, 1023, 511,  0,  0, 1'b0, 2'b01,  3,  1, 1'b0, 1023, 511, 1023, 511, 0, 1};
    tbl[5] = '{2'b10, 1'b0,    7,   8,   7,   8,  0,  0, 1'b1, 2'b10, 18,  1, 1'b1,   7,   8,   7,   8, 0, 1};

    reset      = 1'b1;
    host.req   = '0;
    host.cmd0  = '0;
    host.cmd1  = '0;
    ln_finish  = 1'b0;
    tri_finish = 1'b0;
    ln_x = '0; ln_y = '0; tri_x = '0; tri_y = '0;
    repeat (3) step();
    chk("reset_ctrl", {host.gnt, host.busy, ln_start, tri_reset, pix_valid, host.done, host.err, host.done_id},
        {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_coords", {tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3, ln_x1, ln_y1}, '0);
    reset = 1'b0;
    step();

    d0 = done_cnt;
    ln_finish  = 1'b1;
    tri_finish = 1'b1;
    step();
    step();
    ln_finish  = 1'b0;
    tri_finish = 1'b0;
    step();
    chk("idle_finish_ignored", {host.busy, 32'(done_cnt - d0)}, '0);

    for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

    host.cmd0 = mk(1'b1, 35, 40, 10, 20, 30, 60);
    host.req  = 2'b01;
    ng = 0;
    for (int i = 0; i < 8 && ng == 0; i++) begin
      step();
      if (host.gnt != 2'b00) ng = 1;
    end
    chk("midrun_gnt_seen", ng, 1);
    host.req = '0;
    tri_x = 10'd35;
    tri_y = 9'd40;
    step();
    step();
    chk("midrun_tri_active", {tri_reset, host.busy}, {1'b0, 1'b1});
    reset = 1'b1;
    step();
    chk("midrun_reset_ctrl", {host.busy, tri_reset, pix_valid, host.done, host.err},
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("midrun_reset_coords", {tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3}, '0);
    d0 = done_cnt;
    reset = 1'b0;
    repeat (20) step();
    chk("midrun_no_done", done_cnt - d0, 0);

    host.cmd0 = mk(1'b1, 1, 7, 5, 7, 9, 7);
    host.cmd1 = mk(1'b1, 2, 9, 6, 9, 8, 9);
    host.req  = 2'b11;
    ng = 0;
    for (int i = 0; i < 20 && ng < 3; i++) begin
      step();
      if (host.gnt != 2'b00) begin
        gseq[ng] = host.gnt;
        ng++;
      end
    end
    host.req = '0;
    chk("rr_grant_count", ng, 3);
    if (ng == 3) begin
      chk("rr_grant0", gseq[0], 2'b01);
      chk("rr_grant1", gseq[1], 2'b10);
      chk("rr_grant2", gseq[2], 2'b01);
    end
    repeat (4) step();
    chk("rr_idle_after", host.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
